// File: rtl/ppu_pkg.sv
// Shared PPU constants: scanline timing, sprite fetch FSM encodings,
// sub-cycle names and the SpriteSet load word layout.
package ppu_pkg;

  localparam logic [8:0] FETCH_START = 9'd256;
  localparam logic [8:0] LINE_LAST   = 9'd340;
  localparam logic [8:0] VIS_LINES   = 9'd240;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [2:0] {
    SUB_Y      = 3'd0,
    SUB_TILE   = 3'd1,
    SUB_ATTR   = 3'd2,
    SUB_X      = 3'd3,
    SUB_RD_LO  = 3'd4,
    SUB_CAP_LO = 3'd5,
    SUB_RD_HI  = 3'd6,
    SUB_CAP_HI = 3'd7
  } sub_t;

  localparam int LD_PIX1 = 19;
  localparam int LD_PIX2 = 11;
  localparam int LD_X    = 3;
  localparam int LD_PAL  = 1;
  localparam int LD_PRI  = 0;

  // Empty slot: transparent pixels parked at x=FF
  localparam logic [26:0] LOAD_EMPTY = 27'h0007F8;

endpackage

// File: rtl/sprite_pattern_addr.sv
// Pattern table address for one sprite row/plane,
// covering 8x8 and 8x16 tile layouts and vertical flip.
module sprite_pattern_addr (
  input  logic        obj_size,
  input  logic        pattern_sel,
  input  logic [7:0]  tile,
  input  logic [3:0]  yoff,
  input  logic        vflip,
  input  logic        plane,
  output logic [13:0] addr
);

  logic [3:0] row;
  logic       tbl;
  logic [7:0] t;

  assign row = vflip ? ~yoff : yoff;
  assign tbl = obj_size ? tile[0] : pattern_sel;
  // 8x16: row[3] selects the bottom tile of the pair
  assign t = obj_size ? {tile[7:1], row[3]} : tile;
  assign addr = {1'b0, tbl, t, plane, row[2:0]};

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Sprite fetch sequencer: walks the 8 temp slots in cycles 256..319,
// fetches both pattern planes and loads SpriteSet once per slot.
module sprite_fetch_ctrl
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  logic        i_rendering,
  input  logic        i_obj_size,
  input  logic        i_pattern_sel,
  input  logic [8:0]  i_scanline,
  input  logic [8:0]  i_cycle,
  input  logic [7:0]  i_sprtemp_data,
  output logic [13:0] o_vram_addr,
  output logic        o_vram_rd,
  input  logic [7:0]  i_vram_data,
  output logic [3:0]  o_load,
  output logic [26:0] o_load_in,
  output logic        o_shift_en,
  output logic        o_oam_reset_line,
  output logic        o_fetch_done
);

  logic [1:0]  state;
  logic [3:0]  yoff;
  logic [7:0]  tile;
  logic [7:0]  xpos;
  logic [7:0]  lo;
  logic        empty;
  logic        vflip;
  logic        keep;
  logic        prio;
  logic [1:0]  pal;
  logic [2:0]  slot;
  sub_t        sub;
  logic        start;
  logic        active;
  logic        plane;
  logic [13:0] pat_addr;
  logic [7:0]  lo_bits;
  logic [7:0]  hi_bits;
  logic [26:0] load_word;

  assign slot  = i_cycle[5:3];
  assign sub   = sub_t'(i_cycle[2:0]);
  assign plane = (sub == SUB_RD_HI);
  assign start = (state == ST_IDLE)
              && (i_cycle == FETCH_START)
              && (i_scanline < VIS_LINES);
  assign active = start || (state == ST_FETCH);

  sprite_pattern_addr u_addr (
    .obj_size    (i_obj_size),
    .pattern_sel (i_pattern_sel),
    .tile        (tile),
    .yoff        (yoff),
    .vflip       (vflip),
    .plane       (plane),
    .addr        (pat_addr)
  );

  // SpriteSet shifts LSB first, so unflipped sprites get reversed
  always_comb begin
    lo_bits = lo;
    hi_bits = i_vram_data;
    if (!keep) begin
      for (int i = 0; i < 8; i++) begin
        lo_bits[i] = lo[7-i];
        hi_bits[i] = i_vram_data[7-i];
      end
    end
    load_word = LOAD_EMPTY;
    if (!empty) begin
      load_word = '0;
      load_word[LD_PIX1 +: 8] = lo_bits;
      load_word[LD_PIX2 +: 8] = hi_bits;
      load_word[LD_X +: 8]    = xpos;
      load_word[LD_PAL +: 2]  = pal;
      load_word[LD_PRI]       = prio;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      yoff             <= '0;
      tile             <= '0;
      xpos             <= '0;
      lo               <= '0;
      empty            <= 1'b0;
      vflip            <= 1'b0;
      keep             <= 1'b0;
      prio             <= 1'b0;
      pal              <= '0;
      o_vram_addr      <= '0;
      o_vram_rd        <= 1'b0;
      o_load           <= '0;
      o_load_in        <= '0;
      o_shift_en       <= 1'b0;
      o_oam_reset_line <= 1'b0;
      o_fetch_done     <= 1'b0;
    end else if (i_ce) begin
      o_vram_rd        <= 1'b0;
      o_load           <= '0;
      o_shift_en       <= i_rendering
                       && (i_cycle < FETCH_START)
                       && (i_scanline < VIS_LINES);
      o_oam_reset_line <= (i_cycle == LINE_LAST);
      if (!i_rendering) begin
        state        <= ST_IDLE;
        o_fetch_done <= 1'b0;
      end else if (active) begin
        state <= ST_FETCH;
        unique case (sub)
          SUB_Y: begin
            yoff  <= i_sprtemp_data[3:0];
            empty <= (i_sprtemp_data == 8'hFF);
          end
          SUB_TILE: tile <= i_sprtemp_data;
          SUB_ATTR: begin
            vflip <= i_sprtemp_data[7];
            keep  <= i_sprtemp_data[6];
            prio  <= i_sprtemp_data[5];
            pal   <= i_sprtemp_data[1:0];
          end
          SUB_X: xpos <= i_sprtemp_data;
          SUB_RD_LO, SUB_RD_HI: begin
            o_vram_addr <= pat_addr;
            o_vram_rd   <= !empty;
          end
          SUB_CAP_LO: lo <= i_vram_data;
          SUB_CAP_HI: begin
            o_load    <= 4'b1111;
            o_load_in <= load_word;
            if (slot == 3'd7) begin
              state        <= ST_DONE;
              o_fetch_done <= 1'b1;
            end
          end
        endcase
      end else if (state == ST_DONE && i_cycle == LINE_LAST) begin
        state        <= ST_IDLE;
        o_fetch_done <= 1'b0;
      end
    end
  end

endmodule
